// File: rtl/pipe_skid_stage_pkg.sv
// Shared types for elastic pipeline stages: occupancy encoding and stage bundles.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_occ_t;

  // MEM/WB stage bundle carried as the payload of a pipe_skid_stage.
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] rdata;
    logic [31:0] next_instr;
    logic [7:0]  control;
    logic [31:0] alu_out;
    logic [31:0] ir;
    logic [4:0]  dest;
  } wb_bundle_t;

  localparam int unsigned WB_W = $bits(wb_bundle_t);

  function automatic logic occ_is_full(input pipe_occ_t s);
    return s == PS_FULL;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline register with optional skid entry, flush and stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned WIDTH          = 128,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_occ_t        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             acc_in, acc_out;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // Skid mode decodes in_ready from a flop so out_ready never reaches upstream.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);

  assign acc_in  = in_valid && in_ready;
  assign acc_out = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (acc_in) begin
            main_d  = in_data;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (acc_in && acc_out) begin
            main_d = in_data;
          end else if (acc_in && (SKID != 0)) begin
            skid_d  = in_data;
            state_d = PS_FULL;
          end else if (acc_out) begin
            state_d = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (acc_out) begin
            main_d  = skid_q;
            state_d = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PS_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= !occ_is_full(state_d);
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid && !out_ready),
    .clr  (stall_clr),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage using a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, flush, stall_clr;
  logic [W-1:0]  in_data, out_data;
  logic [1:0]    occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a FIFO of at most two words, last presented word, stall count.
  logic [W-1:0] mq[$];
  logic [W-1:0] mlast;
  int           mcnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH(W),
    .SKID(1),
    .CLEAR_ON_FLUSH(1),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush),
    .stall_clr(stall_clr),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  task automatic model_reset();
    mq.delete();
    mlast = '0;
    mcnt  = 0;
  endtask

  // Called just after a falling edge: drive inputs, advance model, land on the next falling edge.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] d, input logic ordy,
                             input logic fl, input logic sc);
    bit ai, ao;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stall_clr = sc;
    ai = iv && (mq.size() < 2);
    ao = (mq.size() > 0) && ordy;
    if (sc) mcnt = 0;
    else if ((mq.size() > 0) && !ordy && (mcnt < 15)) mcnt++;
    if (fl) begin
      mq.delete();
      mlast = '0;
    end else begin
      if (ao) void'(mq.pop_front());
      if (ai) mq.push_back(d);
    end
    if (mq.size() > 0) mlast = mq[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0 ||
        out_data !== 32'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: valid=%b occ=%0d cnt=%0d data=%h rdy=%b, want 0 0 0 0 1",
               out_valid, occupancy, stall_cnt, out_data, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [W-1:0] vals[3] = '{32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== vals[i] || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream[%0d]: valid=%b data=%h occ=%0d rdy=%b, want 1 %h 1 1",
                 i, out_valid, out_data, occupancy, in_ready, vals[i]);
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_skid_full();
    drive_cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      miscompares++;
      $display("FAIL skid_fill: occ=%0d rdy=%b data=%h, want 2 0 a", occupancy, in_ready, out_data);
    end
    drive_cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (occupancy !== 2'd2 || out_data !== 32'hA) begin
      miscompares++;
      $display("FAIL skid_reject: occ=%0d data=%h, want 2 a", occupancy, out_data);
    end
    drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_drain: data=%h occ=%0d rdy=%b, want b 1 1", out_data, occupancy, in_ready);
    end
    drive_cycle(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_data !== 32'hC || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL skid_next: data=%h valid=%b, want c 1", out_data, out_valid);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    drive_cycle(1'b1, 32'h33, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_data !== 32'h33 || out_valid !== 1'b1 || stall_cnt !== 4'(i)) begin
        miscompares++;
        $display("FAIL stall[%0d]: data=%h valid=%b cnt=%0d, want 33 1 %0d",
                 i, out_data, out_valid, stall_cnt, i);
      end
    end
    drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL stall_clr: cnt=%0d, want 0", stall_cnt);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0 || stall_cnt !== 4'(mcnt)) begin
      miscompares++;
      $display("FAIL flush_full: valid=%b occ=%0d data=%h cnt=%0d, want 0 0 0 %0d",
               out_valid, occupancy, out_data, stall_cnt, mcnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_ghost[%0d]: valid=%b data=%h, want valid 0", i, out_valid, out_data);
      end
    end
    // Flush from ONE while the handshake would otherwise accept.
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_one: valid=%b occ=%0d data=%h, want 0 0 0", out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_saturate();
    drive_cycle(1'b1, 32'h66, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (i == 15 || i == 20) begin
        vectors++;
        if (stall_cnt !== 4'hF) begin
          miscompares++;
          $display("FAIL saturate[%0d]: cnt=%h, want f", i, stall_cnt);
        end
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b occ=%0d cnt=%0d, want 0 0 0", out_valid, occupancy, stall_cnt);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    drive_cycle(1'b1, 32'h5, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h5 || occupancy !== 2'd1) begin
      miscompares++;
      $display("FAIL post_reset: valid=%b data=%h occ=%0d, want 1 5 1", out_valid, out_data, occupancy);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                  ($urandom % 32) == 0, ($urandom % 16) == 0);
      vectors++;
      if (out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size()) ||
          in_ready !== (mq.size() < 2) || out_data !== mlast || stall_cnt !== 4'(mcnt)) begin
        miscompares++;
        $display("FAIL random[%0d]: valid=%b occ=%0d rdy=%b data=%h cnt=%0d, want %b %0d %b %h %0d",
                 i, out_valid, occupancy, in_ready, out_data, stall_cnt,
                 mq.size() > 0, mq.size(), mq.size() < 2, mlast, mcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_full();
    test_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
